// File: rtl/win_avg_monitor.sv
// Sliding-window moving average over the last 2^LOG2_WIN samples, with a hysteresis threshold flag.
// Define WIN_AVG_PEAK_EN to register the highest valid average on `peak`; otherwise `peak` is tied to 0.
module win_avg_monitor #(
    parameter int DW       = 8,
    parameter int LOG2_WIN = 2,
    parameter int TH_HI    = 100,
    parameter int TH_LO    = 80
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DW-1:0]       din,
    input  logic                clr,
    output logic [DW-1:0]       avg,
    output logic                avg_vld,
    output logic                over,
    output logic [LOG2_WIN:0]   fill_cnt,
    output logic [DW-1:0]       peak
);

    localparam int              WIN     = 1 << LOG2_WIN;
    localparam int              SW      = DW + LOG2_WIN;
    localparam int              CW      = LOG2_WIN + 1;
    localparam logic [CW-1:0]   WIN_CNT = CW'(WIN);
    localparam logic [DW-1:0]   TH_HI_V = DW'(TH_HI);
    localparam logic [DW-1:0]   TH_LO_V = DW'(TH_LO);

    typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;

    state_t                 state_q, state_nxt;
    logic [DW-1:0]          win_buf [WIN];
    logic [LOG2_WIN-1:0]    wr_ptr;
    logic [SW-1:0]          sum_q, sum_nxt;
    logic [CW-1:0]          fill_q, fill_nxt;
    logic [DW-1:0]          avg_nxt;
    logic                   over_nxt;

    assign fill_cnt = fill_q;

    always_comb begin
        // NOTE: every signal written here gets a value up front, so no path can infer a latch.
        // Modulo-2^SW arithmetic: the intermediate may wrap, but the final sum always fits.
        sum_nxt   = sum_q + SW'(din) - SW'(win_buf[wr_ptr]);
        avg_nxt   = sum_nxt[SW-1:LOG2_WIN];
        fill_nxt  = (state_q == RUN) ? WIN_CNT : fill_q + CW'(1);
        state_nxt = (fill_nxt == WIN_CNT) ? RUN : FILL;
        over_nxt  = over;
        if (avg_nxt >= TH_HI_V) begin
            over_nxt = 1'b1;
        end else if (avg_nxt <= TH_LO_V) begin
            over_nxt = 1'b0;
        end
    end

`ifdef WIN_AVG_PEAK_EN
    logic [DW-1:0] peak_q;
    assign peak = peak_q;
`else
    assign peak = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffer is reset deliberately; the running sum subtracts the evicted entry, so history must start at zero.
            for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
            wr_ptr  <= '0;
            sum_q   <= '0;
            fill_q  <= '0;
            state_q <= EMPTY;
            avg     <= '0;
            avg_vld <= 1'b0;
            over    <= 1'b0;
`ifdef WIN_AVG_PEAK_EN
            peak_q  <= '0;
`endif
        end else if (clr) begin
            // A simultaneous sample is dropped; avg deliberately keeps its last value.
            for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
            wr_ptr  <= '0;
            sum_q   <= '0;
            fill_q  <= '0;
            state_q <= EMPTY;
            avg_vld <= 1'b0;
            over    <= 1'b0;
`ifdef WIN_AVG_PEAK_EN
            peak_q  <= '0;
`endif
        end else if (en) begin
            win_buf[wr_ptr] <= din;
            wr_ptr          <= wr_ptr + LOG2_WIN'(1);
            sum_q           <= sum_nxt;
            fill_q          <= fill_nxt;
            state_q         <= state_nxt;
            avg_vld         <= (state_nxt == RUN);
            if (state_nxt == RUN) begin
                avg  <= avg_nxt;
                over <= over_nxt;
`ifdef WIN_AVG_PEAK_EN
                if (avg_nxt > peak_q) peak_q <= avg_nxt;
`endif
            end
        end else begin
            avg_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_win_avg_monitor.sv
// Self-checking bench for win_avg_monitor: queue-based window model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_win_avg_monitor;

    localparam int DW       = 8;
    localparam int LOG2_WIN = 2;
    localparam int WIN      = 1 << LOG2_WIN;
    localparam int TH_HI    = 100;
    localparam int TH_LO    = 80;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic [DW-1:0]       din = '0;
    logic                clr = 1'b0;
    logic [DW-1:0]       avg;
    logic                avg_vld;
    logic                over;
    logic [LOG2_WIN:0]   fill_cnt;
    logic [DW-1:0]       peak;

    int n_checks = 0;
    int n_errors = 0;

    win_avg_monitor #(.DW(DW), .LOG2_WIN(LOG2_WIN), .TH_HI(TH_HI), .TH_LO(TH_LO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
        .avg(avg), .avg_vld(avg_vld), .over(over), .fill_cnt(fill_cnt), .peak(peak)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue holding the accepted samples of the current window.
    int q[$];
    int m_avg, m_vld, m_over, m_peak;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_avg = 0; m_vld = 0; m_over = 0; m_peak = 0;
        end else begin
            m_vld = 0;
            if (clr) begin
                q.delete();
                m_over = 0;
                m_peak = 0;
            end else if (en) begin
                int s;
                q.push_back(int'(din));
                if (q.size() > WIN) void'(q.pop_front());
                if (q.size() == WIN) begin
                    s = 0;
                    foreach (q[i]) s += q[i];
                    m_avg = s / WIN;
                    m_vld = 1;
                    if (m_avg >= TH_HI) m_over = 1;
                    else if (m_avg <= TH_LO) m_over = 0;
                    if (m_avg > m_peak) m_peak = m_avg;
                end
            end
        end
    end

    function automatic int exp_peak();
`ifdef WIN_AVG_PEAK_EN
        return m_peak;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("model avg", int'(avg), m_avg);
            check("model avg_vld", int'(avg_vld), m_vld);
            check("model over", int'(over), m_over);
            check("model fill_cnt", int'(fill_cnt), q.size());
            check("model peak", int'(peak), exp_peak());
        end
    end

    // Drive one cycle of inputs; returns at the negedge where the result is visible.
    task automatic cyc(input logic e, input int d, input logic c);
        en = e; din = DW'(d); clr = c;
        @(negedge clk);
    endtask

    int fill_in[4]  = '{10, 20, 30, 40};
    int slide_in[5] = '{50, 60, 70, 80, 90};
    int slide_av[5] = '{35, 45, 55, 65, 75};
    int hyst_av[4]  = '{107, 95, 82, 70};
    int hyst_ov[4]  = '{1, 1, 1, 0};

    initial begin
        #50 rst_n = 1'b1;
        @(negedge clk);
        check("reset avg", int'(avg), 0);
        check("reset fill_cnt", int'(fill_cnt), 0);
        check("reset over", int'(over), 0);

        // Window fill
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, fill_in[i], 1'b0);
            check("fill fill_cnt", int'(fill_cnt), i + 1);
            check("fill avg_vld", int'(avg_vld), (i == 3) ? 1 : 0);
        end
        check("fill avg", int'(avg), 25);

        // Sliding with pointer wrap
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, slide_in[i], 1'b0);
            check("slide avg", int'(avg), slide_av[i]);
            check("slide avg_vld", int'(avg_vld), 1);
        end

        // Hysteresis
        for (int i = 0; i < 4; i++) cyc(1'b1, 120, 1'b0);
        check("hyst high avg", int'(avg), 120);
        check("hyst high over", int'(over), 1);
`ifdef WIN_AVG_PEAK_EN
        check("peak 120", int'(peak), 120);
`endif
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 70, 1'b0);
            check("hyst fall avg", int'(avg), hyst_av[i]);
            check("hyst fall over", int'(over), hyst_ov[i]);
        end

        // Idle gap: outputs hold
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 99, 1'b0);
            check("idle avg_vld", int'(avg_vld), 0);
            check("idle avg", int'(avg), 70);
            check("idle fill_cnt", int'(fill_cnt), 4);
        end

        // Saturation
        for (int i = 0; i < 4; i++) cyc(1'b1, 255, 1'b0);
        check("sat avg", int'(avg), 255);
        check("sat over", int'(over), 1);

        // clr collides with en: sample dropped
        cyc(1'b1, 200, 1'b1);
        check("clr fill_cnt", int'(fill_cnt), 0);
        check("clr over", int'(over), 0);
        check("clr avg_vld", int'(avg_vld), 0);
        check("clr avg held", int'(avg), 255);
        check("clr peak", int'(peak), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8, 1'b0);
            check("refill avg_vld", int'(avg_vld), (i == 3) ? 1 : 0);
        end
        check("refill avg", int'(avg), 8);

        // Build over=1 again, then reset asynchronously between edges
        for (int i = 0; i < 2; i++) cyc(1'b1, 200, 1'b0);
        check("pre-reset avg", int'(avg), 104);
        check("pre-reset over", int'(over), 1);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async avg", int'(avg), 0);
        check("async over", int'(over), 0);
        check("async fill_cnt", int'(fill_cnt), 0);
        check("async avg_vld", int'(avg_vld), 0);
        check("async peak", int'(peak), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Fresh window after reset starts from zeroed history
        for (int i = 0; i < 4; i++) cyc(1'b1, 40 + 4 * i, 1'b0);
        check("post-reset avg", int'(avg), 46);
        check("post-reset over", int'(over), 0);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
